// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies one 256-byte RAM page into OAM.
//   Trigger: CPU write to $4014 while idle latches the page; the CPU is held for
//   513 or 514 CPU cycles depending on the parity of the trigger cycle.
//   Inputs : clk, reset_n (async, active-low), ce (CPU-cycle enable), cpu_addr,
//            cpu_dout, cpu_wr, oam_base (only with OAM_DMA_OAMADDR_EN), ram_dout
//   Outputs: cpu_halt, ram_addr, ram_rd, oam_addr, oam_din, oam_wren, done
//   Build option: define OAM_DMA_OAMADDR_EN to offset OAM writes by oam_base.
module oam_dma (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic [7:0]  oam_base,
  input  logic [7:0]  ram_dout,
  output logic        cpu_halt,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_din,
  output logic        oam_wren,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic parity_q, align_q, align_d, done_q, done_d;
  logic [7:0] page_q, page_d, idx_q, idx_d, base_q, base_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      align_q  <= 1'b0;
      page_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      if (ce) begin
        parity_q <= ~parity_q;
        state_q  <= state_d;
        align_q  <= align_d;
        page_q   <= page_d;
        idx_q    <= idx_d;
        base_q   <= base_d;
      end
    end
  end
  // Registers only load on ce edges, so next-state logic need not gate on ce.
  always_comb begin
    state_d = state_q;
    align_d = align_q;
    page_d  = page_q;
    idx_d   = idx_q;
    base_d  = base_q;
    case (state_q)
      IDLE: if (cpu_wr && cpu_addr == 16'h4014) begin
        page_d  = cpu_dout;
        align_d = parity_q;
        idx_d   = '0;
        base_d  = oam_base;
        state_d = HALT;
      end
      HALT:    state_d = align_q ? ALIGN : READ;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  assign done_d   = ce && state_q == WRITE && idx_q == 8'hFF;
  assign done     = done_q;
  assign cpu_halt = state_q != IDLE;
  // WRITE keeps the read address so ram_dout stays valid through slow ce.
  assign ram_rd   = state_q == READ || state_q == WRITE;
  assign ram_addr = ram_rd ? {page_q, idx_q} : 16'h0000;
  assign oam_din  = ram_dout;
  assign oam_wren = state_q == WRITE && ce;
`ifdef OAM_DMA_OAMADDR_EN
  assign oam_addr = base_q + idx_q;
`else
  logic unused_base;
  assign unused_base = ^base_q;
  assign oam_addr = idx_q;
`endif
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma with ce every third clk.
module tb_oam_dma;
  logic        clk = 1'b0, reset_n = 1'b0, ce, cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0, oam_base = '0, ram_dout = '0;
  logic        cpu_halt, ram_rd, oam_wren, done;
  logic [15:0] ram_addr, last_rd = '0;
  logic [7:0]  oam_addr, oam_din;
  logic [1:0]  cc = '0;
  logic        par, oam_clr = 1'b0;
  logic [7:0]  oam [256];
  int          wr_cnt = 0, bad_wren = 0, checks = 0, errors = 0;
  int          halts, dones;
  logic        ok;

  oam_dma dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .oam_base(oam_base), .ram_dout(ram_dout), .cpu_halt(cpu_halt),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .oam_addr(oam_addr), .oam_din(oam_din),
    .oam_wren(oam_wren), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cc <= (cc == 2'd2) ? 2'd0 : cc + 2'd1;
  assign ce = (cc == 2'd2);
  always @(posedge clk or negedge reset_n)
    if (!reset_n) par <= 1'b0;
    else if (ce) par <= ~par;

  function automatic logic [7:0] rb(input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ (a[15:8] * 8'd29) ^ 8'h5A;
  endfunction

  always @(posedge clk) ram_dout <= rb(ram_addr);
  always @(posedge clk) begin
    if (oam_clr) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
      wr_cnt <= 0;
    end else if (oam_wren) begin
      oam[oam_addr] <= oam_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_rd) last_rd <= ram_addr;
  end
  always @(negedge clk) if (oam_wren && !ce) bad_wren <= bad_wren + 1;

  task automatic clear_oam;
    @(negedge clk); oam_clr = 1'b1;
    @(negedge clk); oam_clr = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] pg, input logic pw);
    logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = ce && par == pw;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL trigger_wait got=0 want=1"); end
    cpu_addr = 16'h4014; cpu_dout = pg; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = '0;
  endtask

  // Counts ce edges spent halted; inj >= 0 fires a $4014 write of 8'h07 at that ce.
  task automatic wait_end(input int inj, output int h, output int d);
    h = 0; d = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cpu_wr = 1'b0;
      if (done) d++;
      if (!cpu_halt) break;
      if (ce) begin
        if (h == inj) begin cpu_addr = 16'h4014; cpu_dout = 8'h07; cpu_wr = 1'b1; end
        h++;
      end
    end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) d++; end
  endtask

  task automatic check_oam(input logic [7:0] pg, input logic [7:0] off, input int lo, input int hi, input string nm);
    logic [7:0] a, b, want;
    for (int i = lo; i <= hi; i++) begin
      b = i[7:0]; a = off + b; want = rb({pg, b});
      checks++;
      if (oam[a] !== want) begin errors++; $display("FAIL %s oam[%02h] got=%02h want=%02h", nm, a, oam[a], want); end
    end
  endtask

  task automatic check_run(input string nm, input int hw, input int ww);
    checks++; if (halts !== hw) begin errors++; $display("FAIL %s_halts got=%0d want=%0d", nm, halts, hw); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL %s_done got=%0d want=1", nm, dones); end
    checks++; if (wr_cnt !== ww) begin errors++; $display("FAIL %s_writes got=%0d want=%0d", nm, wr_cnt, ww); end
    checks++; if (bad_wren !== 0) begin errors++; $display("FAIL %s_wren_no_ce got=%0d want=0", nm, bad_wren); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rst_halt got=%b want=0", cpu_halt); end
    checks++; if (oam_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b want=0", oam_wren); end
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got=%b want=0", ram_rd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%04h want=0000", ram_addr); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_dma_even;
    clear_oam;
    trigger(8'h02, 1'b0);
    wait_end(-1, halts, dones);
    check_run("even", 513, 256);
    check_oam(8'h02, 8'h00, 0, 255, "even");
  endtask

  task automatic test_dma_odd;
    clear_oam;
    trigger(8'h02, 1'b1);
    wait_end(-1, halts, dones);
    check_run("odd", 514, 256);
    check_oam(8'h02, 8'h00, 0, 255, "odd");
  endtask

  task automatic test_ignore_write;
    clear_oam;
    trigger(8'h02, 1'b0);
    wait_end(100, halts, dones);
    check_run("ignore", 513, 256);
    check_oam(8'h02, 8'h00, 0, 255, "ignore");
  endtask

  task automatic test_reset_mid;
    logic hit = 1'b0;
    clear_oam;
    trigger(8'h02, 1'b0);
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = ram_rd && ram_addr == 16'h0240;
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reach_40 got=0 want=1"); end
    reset_n = 1'b0; #1;
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL mid_halt got=%b want=0", cpu_halt); end
    checks++; if (oam_wren !== 1'b0) begin errors++; $display("FAIL mid_wren got=%b want=0", oam_wren); end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b want=0", cpu_halt); end
    checks++; if (wr_cnt !== 64) begin errors++; $display("FAIL mid_writes got=%0d want=64", wr_cnt); end
    check_oam(8'h02, 8'h00, 0, 63, "mid_kept");
    for (int i = 64; i < 256; i++) begin
      checks++;
      if (oam[i] !== 8'hEE) begin errors++; $display("FAIL mid_untouched oam[%02h] got=%02h want=ee", i, oam[i]); end
    end
    clear_oam;
    trigger(8'h02, 1'b1);
    wait_end(-1, halts, dones);
    check_run("after_rst", 514, 256);
    check_oam(8'h02, 8'h00, 0, 255, "after_rst");
  endtask

  task automatic test_oamaddr;
    logic [7:0] off;
`ifdef OAM_DMA_OAMADDR_EN
    off = 8'hF0;
`else
    off = 8'h00;
`endif
    clear_oam;
    oam_base = 8'hF0;
    trigger(8'h02, 1'b0);
    oam_base = 8'h33;
    wait_end(-1, halts, dones);
    check_run("base", 513, 256);
    check_oam(8'h02, off, 0, 255, "base");
    oam_base = 8'h00;
  endtask

  task automatic test_page_ff;
    clear_oam;
    trigger(8'hFF, 1'b0);
    wait_end(-1, halts, dones);
    check_run("pageff", 513, 256);
    checks++; if (last_rd !== 16'hFFFF) begin errors++; $display("FAIL pageff_last got=%04h want=ffff", last_rd); end
    checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL pageff_idle_addr got=%04h want=0000", ram_addr); end
    check_oam(8'hFF, 8'h00, 0, 255, "pageff");
  endtask

  initial begin
    test_reset;
    test_dma_even;
    test_dma_odd;
    test_ignore_write;
    test_reset_mid;
    test_oamaddr;
    test_page_ff;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
